sc_count_share_array: RTL and testbench



---
 rtl/sc_count_pkg.sv | 15 +
 rtl/sc_lane_counter.sv | 24 ++
 rtl/sc_count_share_array.sv | 85 ++++++++
 tb/tb_sc_count_share_array.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_count_pkg.sv
// Shared types and sizing helpers for the stochastic-to-binary counter array.
package sc_count_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  function automatic int lane_count(input int bdim, input int sdim);
    return bdim * sdim;
  endfunction

  // One extra bit so a window of all ones reads exactly 2^RWID.
  function automatic int cnt_width(input int rwid);
    return rwid + 1;
  endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// Per-lane ones counter; a clear takes priority over an increment.
module sc_lane_counter #(
  parameter int CWID = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc_en,
  input  logic            bit_in,
  output logic [CWID-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc_en) begin
      count <= count + CWID'(bit_in);
    end
  end

endmodule

// File: rtl/sc_count_share_array.sv
// Stochastic-to-binary decoder: counts ones per lane over 2^RWID valid cycles, then holds the result behind valid/ready.
module sc_count_share_array
  import sc_count_pkg::*;
#(
  parameter  int RWID  = 8,
  parameter  int BDIM  = 16,
  parameter  int SDIM  = 32,
  localparam int NLANE = lane_count(BDIM, SDIM),
  localparam int CWID  = cnt_width(RWID)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NLANE-1:0] bitIn,
  input  logic             bitValid,
  output logic [RWID:0]    binOut [NLANE],
  output logic             outValid,
  input  logic             outReady,
  output logic             busy
);

  typedef logic [CWID-1:0] cnt_t;

  state_t          state_q, state_d;
  logic [RWID-1:0] win_cnt;
  cnt_t            lane_cnt [NLANE];
  logic            handshake, start_acc, step, win_end;

  assign handshake = (state_q == HOLD) && outValid && outReady;
  // A start is honoured from IDLE, or on the handshake edge to skip the idle bubble.
  assign start_acc = start && ((state_q == IDLE) || handshake);
  assign step      = (state_q == ACCUM) && bitValid;
  assign win_end   = step && (win_cnt == '1);
  assign busy      = (state_q == ACCUM);

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (win_end)   state_d = HOLD;
      HOLD:    if (handshake) state_d = start ? ACCUM : IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc)   win_cnt <= '0;
      else if (step)   win_cnt <= win_cnt + RWID'(1);
    end
  end

  // NOTE: the result array is a bank of flops, not a RAM, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      for (int i = 0; i < NLANE; i++) binOut[i] <= '0;
    end else if (win_end) begin
      outValid <= 1'b1;
      for (int i = 0; i < NLANE; i++) binOut[i] <= lane_cnt[i] + CWID'(bitIn[i]);
    end else if (handshake) begin
      outValid <= 1'b0;
    end
  end

  for (genvar b = 0; b < BDIM; b++) begin : g_grp
    for (genvar s = 0; s < SDIM; s++) begin : g_lane
      localparam int L = b * SDIM + s;
      sc_lane_counter #(.CWID(CWID)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_acc),
        .inc_en (step),
        .bit_in (bitIn[L]),
        .count  (lane_cnt[L])
      );
    end
  end

endmodule

// File: tb/tb_sc_count_share_array.sv
// Bench for sc_count_share_array: window-level model compared every cycle plus literal checkpoints.
module tb_sc_count_share_array;

  localparam int RWID  = 8;
  localparam int BDIM  = 2;
  localparam int SDIM  = 4;
  localparam int NLANE = BDIM * SDIM;
  localparam int WIN   = 1 << RWID;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NLANE-1:0] bit_in;
  logic             bit_valid;
  logic [RWID:0]    bin_out [NLANE];
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  // Window-level model: "in a window", ones seen so far, results on offer.
  bit m_active, m_valid;
  int m_n;
  int m_ones [NLANE];
  int m_out  [NLANE];

  sc_count_share_array #(.RWID(RWID), .BDIM(BDIM), .SDIM(SDIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bitIn    (bit_in),
    .bitValid (bit_valid),
    .binOut   (bin_out),
    .outValid (out_valid),
    .outReady (out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_valid  = 0;
    m_n      = 0;
    for (int i = 0; i < NLANE; i++) begin
      m_ones[i] = 0;
      m_out[i]  = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = start && !m_active && (!m_valid || out_ready);
    if (m_valid && out_ready) m_valid = 0;
    if (m_active && bit_valid) begin
      for (int i = 0; i < NLANE; i++) m_ones[i] += int'(bit_in[i]);
      m_n++;
      if (m_n == WIN) begin
        m_out    = m_ones;
        m_valid  = 1;
        m_active = 0;
      end
    end
    if (acc) begin
      m_active = 1;
      m_n      = 0;
      for (int i = 0; i < NLANE; i++) m_ones[i] = 0;
    end
  endtask

  // Drive one cycle of inputs, then advance the model across the rising edge.
  task automatic cyc(input logic s, input logic [NLANE-1:0] b, input logic v, input logic r);
    @(negedge clk);
    #1;
    start = s; bit_in = b; bit_valid = v; out_ready = r;
    @(posedge clk);
    model_step();
  endtask

  function automatic logic [NLANE-1:0] pat(input int mode, input int k);
    case (mode)
      1:       return {5'b11111, 1'(k < 64), 1'(k % 2 == 0), 1'b0};
      2:       return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic run_window(input int mode, input bit gap);
    int k = 0;
    int c = 0;
    while (k < WIN) begin
      if (gap && (c % 3 == 2)) cyc(1'b0, 8'hFF, 1'b0, 1'b0);
      else begin
        cyc(1'b0, pat(mode, k), 1'b1, 1'b0);
        k++;
      end
      c++;
    end
  endtask

  task automatic check_lanes(input string tag, input int e [NLANE]);
    for (int i = 0; i < NLANE; i++) check($sformatf("%s lane%0d", tag, i), int'(bin_out[i]), e[i]);
  endtask

  // Single compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("model out_valid", int'(out_valid), int'(m_valid));
    check("model busy", int'(busy), int'(m_active));
    for (int i = 0; i < NLANE; i++) check($sformatf("model bin_out%0d", i), int'(bin_out[i]), m_out[i]);
  end

  initial begin
    int all_ones [NLANE] = '{256, 256, 256, 256, 256, 256, 256, 256};
    int zeros    [NLANE] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int exp2     [NLANE] = '{0, 128, 64, 256, 256, 256, 256, 256};
    int exp6     [NLANE] = '{256, 256, 256, 256, 0, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; bit_in = '0; bit_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check_lanes("reset", zeros);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: all ones; outValid exactly on cycle 257 after start.
    cyc(1'b1, '0, 1'b0, 1'b0);
    for (int k = 0; k < WIN - 1; k++) cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    #1;
    check("c1 out_valid before last bit", int'(out_valid), 0);
    check("c1 busy before last bit", int'(busy), 1);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    #1;
    check("c1 out_valid latency", int'(out_valid), 1);
    check("c1 busy falls", int'(busy), 0);
    check_lanes("c1", all_ones);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // 2: mixed lane patterns.
    cyc(1'b1, '0, 1'b0, 1'b0);
    run_window(1, 1'b0);
    #1;
    check("c2 out_valid", int'(out_valid), 1);
    check_lanes("c2", exp2);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // 3: same with every third cycle invalid.
    cyc(1'b1, '0, 1'b0, 1'b0);
    run_window(1, 1'b1);
    #1;
    check("c3 out_valid", int'(out_valid), 1);
    check_lanes("c3", exp2);

    // 4: back-pressure with an ignored start.
    for (int i = 0; i < 10; i++) cyc(1'(i == 4), 8'hFF, 1'b1, 1'b0);
    #1;
    check("c4 out_valid held", int'(out_valid), 1);
    check("c4 busy stays low", int'(busy), 0);
    check_lanes("c4", exp2);
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    check("c4 out_valid after handshake", int'(out_valid), 0);
    check("c4 busy after handshake", int'(busy), 0);

    // 5: reset mid-window, then a clean window.
    cyc(1'b1, '0, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("c5 reset out_valid", int'(out_valid), 0);
    check("c5 reset busy", int'(busy), 0);
    check_lanes("c5 reset", zeros);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, '0, 1'b0, 1'b0);
    run_window(0, 1'b0);
    #1;
    check_lanes("c5", all_ones);

    // 6: start on the handshake edge.
    cyc(1'b1, '0, 1'b0, 1'b1);
    #1;
    check("c6 out_valid drops", int'(out_valid), 0);
    check("c6 busy rises", int'(busy), 1);
    run_window(2, 1'b0);
    #1;
    check("c6 out_valid", int'(out_valid), 1);
    check_lanes("c6", exp6);
    cyc(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
